vector_result_writeback: RTL and testbench



---
 rtl/vector_result_writeback_pkg.sv | 15 +
 rtl/vector_wb_fifo.sv | 75 +++++++
 rtl/vector_result_writeback.sv | 86 ++++++++
 tb/tb_vector_result_writeback.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vector_result_writeback_pkg.sv
// Shared vector types: register address, result vector and writeback entry.
package Vector;

    localparam int VEC_NUM_ELEMS = 8;
    localparam int VEC_ELEM_SIZE = 16;

    typedef logic [4:0] Vreg_addr;
    typedef logic [VEC_NUM_ELEMS*VEC_ELEM_SIZE-1:0] Vector_data;

    typedef struct packed {
        Vreg_addr   vrt;
        Vector_data data;
    } Wb_entry;

endpackage

// File: rtl/vector_wb_fifo.sv
// Generic synchronous circular-buffer FIFO with occupancy count and a view of
// the stored entries for associative lookups by the parent.
module vector_wb_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  T                       i_data,
    output T                       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output T                       o_mem [DEPTH],
    output logic [DEPTH-1:0]       o_occupied
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [PW:0]   r_count;
    T              r_mem [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_off;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign o_mem   = r_mem;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Slot i is live when its distance from the read pointer is below the count.
    always_comb begin
        o_occupied = '0;
        w_off      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off         = PW'(i) - r_rptr;
            o_occupied[i] = ({1'b0, w_off} < r_count);
        end
    end

endmodule

// File: rtl/vector_result_writeback.sv
// Queues permute results until the shared VRF write port grants them, with
// backpressure to the permute stage and a pending-write hazard query.
module vector_result_writeback
    import Vector::*;
#(
    parameter int NUM_ELEMS = VEC_NUM_ELEMS,
    parameter int ELEM_SIZE = VEC_ELEM_SIZE,
    parameter int DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [4:0]                     in_vrt,
    input  logic [NUM_ELEMS*ELEM_SIZE-1:0] in_data,
    output logic                           stall,
    output logic                           vrf_we,
    output logic [4:0]                     vrf_addr,
    output logic [NUM_ELEMS*ELEM_SIZE-1:0] vrf_data,
    input  logic                           vrf_grant,
    input  logic [4:0]                     query_vr,
    output logic                           query_hit,
    output logic [$clog2(DEPTH):0]         count
);

    // Same layout as Vector::Wb_entry, but sized by this instance's parameters.
    typedef struct packed {
        Vreg_addr                       vrt;
        logic [NUM_ELEMS*ELEM_SIZE-1:0] data;
    } wb_entry_t;

    wb_entry_t        w_in_entry;
    wb_entry_t        w_head;
    wb_entry_t        w_mem [DEPTH];
    logic [DEPTH-1:0] w_occupied;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_in_entry = wb_entry_t'{vrt: in_vrt, data: in_data};

    assign stall    = w_full;
    assign vrf_we   = !w_empty;
    assign vrf_addr = w_head.vrt;
    assign vrf_data = w_head.data;

    assign w_push = in_valid && !stall;
    assign w_pop  = vrf_we && vrf_grant;

    vector_wb_fifo #(
        .T     (wb_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_data     (w_in_entry),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (count),
        .o_mem      (w_mem),
        .o_occupied (w_occupied)
    );

    // Incoming result counts as pending even while stalled: conservative on purpose.
    always_comb begin
        query_hit = in_valid && (in_vrt == query_vr);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_occupied[i] && (w_mem[i].vrt == query_vr)) begin
                query_hit = 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_stalled : assert property (@(posedge clk) disable iff (reset)
        stall |-> !w_push);
    a_head_stable : assert property (@(posedge clk) disable iff (reset)
        (vrf_we && !vrf_grant) |=> ($stable(vrf_addr) && $stable(vrf_data)));
    a_count_bound : assert property (@(posedge clk) disable iff (reset)
        count <= ($clog2(DEPTH)+1)'(DEPTH));
`endif

endmodule

// File: tb/tb_vector_result_writeback.sv
// Scoreboard bench: a reference occupancy model queues expected writes, and a
// separate monitor pops and compares them whenever the VRF write is granted.
module tb_vector_result_writeback;

    localparam int NE = 8;
    localparam int ES = 16;
    localparam int D  = 4;
    localparam int DW = NE*ES;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [4:0]    in_vrt;
    logic [DW-1:0] in_data;
    logic          stall;
    logic          vrf_we;
    logic [4:0]    vrf_addr;
    logic [DW-1:0] vrf_data;
    logic          vrf_grant;
    logic [4:0]    query_vr;
    logic          query_hit;
    logic [2:0]    count;

    typedef struct packed {
        logic [4:0]    vrt;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   mcount;
    int   n_checks;
    int   n_pass;
    logic m_hit;
    logic m_push;
    logic m_pop;
    exp_t m_entry;
    logic tog;

    vector_result_writeback #(
        .NUM_ELEMS (NE),
        .ELEM_SIZE (ES),
        .DEPTH     (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_vrt    (in_vrt),
        .in_data   (in_data),
        .stall     (stall),
        .vrf_we    (vrf_we),
        .vrf_addr  (vrf_addr),
        .vrf_data  (vrf_data),
        .vrf_grant (vrf_grant),
        .query_vr  (query_vr),
        .query_hit (query_hit),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [DW-1:0] mk(input logic [4:0] v);
        mk = {NE{v, 3'b101, v, 3'b010}};
    endfunction

    // Reference model: occupancy, stall/request/hazard expectations, expected writes.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            mcount = 0;
        end else begin
            m_hit = in_valid && (in_vrt == query_vr);
            foreach (sb[i]) if (sb[i].vrt == query_vr) m_hit = 1'b1;
            chk("count", count, mcount);
            chk("stall", stall, mcount == D);
            chk("vrf_we", vrf_we, mcount != 0);
            chk("query_hit", query_hit, m_hit);
            m_push = in_valid && (mcount != D);
            m_pop  = (mcount != 0) && vrf_grant;
            if (m_push) sb.push_back(exp_t'{vrt: in_vrt, data: in_data});
            mcount = mcount + int'(m_push) - int'(m_pop);
        end
    end

    // Monitor: every granted write must match the oldest expected entry.
    always @(negedge clk) begin
        #1;
        if (!reset && vrf_we && vrf_grant) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {{(DW-5){1'b0}}, vrf_addr}, '1);
            end else begin
                m_entry = sb.pop_front();
                chk("wr_addr", {{(DW-5){1'b0}}, vrf_addr}, {{(DW-5){1'b0}}, m_entry.vrt});
                chk("wr_data", vrf_data, m_entry.data);
            end
        end
    end

    task automatic step(input logic v, input logic [4:0] vrt, input logic [DW-1:0] d, input logic g);
        in_valid  = v;
        in_vrt    = vrt;
        in_data   = d;
        vrf_grant = g;
        @(posedge clk);
        #1;
    endtask

    // Hold a result until accepted, toggling grant every cycle.
    task automatic push_hold(input logic [4:0] vrt);
        logic acc;
        for (int k = 0; k < 8; k++) begin
            acc = !stall;
            tog = ~tog;
            step(1'b1, vrt, mk(vrt), tog);
            if (acc) return;
        end
        chk("push_timeout", 1, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_we"}, vrf_we, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_addr"}, {{(DW-5){1'b0}}, vrf_addr}, 0);
        chk({tag, "_data"}, vrf_data, 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mcount   = 0;
        tog      = 1'b0;
        reset    = 1'b1;
        query_vr = 5'd31;
        step(1'b0, 5'd0, '0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0);
        reset = 1'b0;
        chk_idle("reset");

        // Single result, grant held high
        step(1'b1, 5'd3, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 1'b1);
        chk("single_we", vrf_we, 1);
        chk("single_addr", {{(DW-5){1'b0}}, vrf_addr}, 3);
        step(1'b0, 5'd0, '0, 1'b1);
        chk("single_count", count, 0);

        // Fill with grant low; a fifth result must be refused
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), mk(5'(i)), 1'b0);
        chk("fill_stall", stall, 1);
        chk("fill_count", count, 4);
        step(1'b1, 5'd9, mk(5'd9), 1'b0);
        chk("fill_reject_count", count, 4);
        in_valid = 1'b0;
        query_vr = 5'd2;
        #1 chk("full_hit", query_hit, 1);
        query_vr = 5'd8;
        #1 chk("full_miss", query_hit, 0);
        query_vr = 5'd31;

        // Drain from full while holding vrt=5
        step(1'b1, 5'd5, mk(5'd5), 1'b1);
        chk("drain_stall_drop", stall, 0);
        chk("drain_count", count, 3);
        step(1'b1, 5'd5, mk(5'd5), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, '0, 1'b1);
        chk("drain_empty", count, 0);

        // Concurrent push/pop with pointer wrap
        for (int i = 0; i < 10; i++) begin
            push_hold(5'(10 + i));
            chk("wrap_bound", count <= 3'd4, 1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, '0, 1'b1);
        chk("wrap_empty", count, 0);

        // Hazard query
        step(1'b1, 5'd7, mk(5'd7), 1'b0);
        in_valid = 1'b0;
        query_vr = 5'd7;
        #1 chk("hz_queued", query_hit, 1);
        query_vr = 5'd8;
        #1 chk("hz_miss", query_hit, 0);
        in_valid = 1'b1;
        in_vrt   = 5'd8;
        #1 chk("hz_incoming", query_hit, 1);
        step(1'b1, 5'd8, mk(5'd8), 1'b0);
        step(1'b1, 5'd9, mk(5'd9), 1'b0);
        query_vr = 5'd31;
        chk("pre_reset_count", count, 3);

        // Reset mid-operation discards queued entries
        reset = 1'b1;
        step(1'b0, 5'd0, '0, 1'b0);
        reset = 1'b0;
        chk_idle("midreset");
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, '0, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
